multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM that sequences the shared datapath (register file, immediate generator, ALU, unified instruction/data memory) of the multi-cycle RV32I core, one instruction at a time. Decodes the opcode held in the instruction register and drives the per-cycle select, enable and memory-handshake signals. Implements the R-type, load, store and branch subset. Keeps a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- Opcode  in  7  Instruction[6:0] from instruction register
- Funct3  in  3  Instruction[14:12], used for branch condition only
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes current request this cycle
- MemReq  out  1  memory request valid
- MemWrite  out  1  request is a write (qualifies MemReq)
- IRWrite  out  1  load instruction register
- PCWrite  out  1  load PC
- PCSrc  out  1  0 = PC+4, 1 = branch target (ALUOut)
- RegWrite  out  1  register-file write enable
- MemToReg  out  1  0 = ALUOut, 1 = memory data
- ALUSrcB  out  1  0 = rs2, 1 = immediate
- ALUOp  out  2  00 add, 01 sub, 10 funct-decode
- ImmSel  out  2  00 I, 01 S, 10 B, 11 zero
- Illegal  out  1  sticky unsupported-opcode flag
- InstrCount  out  CNT_W  instructions retired

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, LOAD_WB, MEM_WR, EXEC_R, R_WB, BRANCH, TRAP.
- FETCH: MemReq=1, MemWrite=0. Stay while MemReady=0. On MemReady=1: IRWrite=1, PCWrite=1, PCSrc=0, -> DECODE.
- DECODE: Opcode 0110011 -> EXEC_R; 0000011 or 0100011 -> MEM_ADDR; 1100011 -> BRANCH; other -> TRAP.
- EXEC_R: ALUSrcB=0, ALUOp=10 -> R_WB. R_WB: RegWrite=1, MemToReg=0 -> FETCH.
- MEM_ADDR: ALUSrcB=1, ALUOp=00; -> MEM_RD if load, MEM_WR if store.
- MEM_RD: MemReq=1, MemWrite=0; hold until MemReady -> LOAD_WB. LOAD_WB: RegWrite=1, MemToReg=1 -> FETCH.
- MEM_WR: MemReq=1, MemWrite=1; hold until MemReady -> FETCH.
- BRANCH: ALUSrcB=0, ALUOp=01, PCSrc=1; PCWrite = (Funct3==000 & Zero) | (Funct3==001 & ~Zero); other Funct3 -> no PC update, not illegal. -> FETCH.
- TRAP: all enables 0, MemReq=0, Illegal=1; stays until rst.
- ImmSel purely combinational from Opcode in every state: load 00, store 01, branch 10, else 11.
- Control outputs are Moore from state except IRWrite/PCWrite (qualified by MemReady / Zero).
- InstrCount increments by 1 in the cycle leaving R_WB, LOAD_WB, MEM_WR (on MemReady), BRANCH; wraps modulo 2^CNT_W. TRAP does not count.

## Timing
- Reset: state=FETCH, InstrCount=0, Illegal=0; while rst=1 all outputs forced 0 (incl. MemReq). MemReq first asserts in first cycle after rst deasserts.
- rst mid-instruction (including mid memory wait): abort immediately, no further writes; MemReady during rst ignored.
- Zero-wait memory cycle counts: R-type 4, load 5, store 4, branch 3. Each MemReady=0 cycle in FETCH/MEM_RD/MEM_WR adds one.
- MemReq/MemWrite stable while waiting; MemReady outside a request state ignored.
- InstrCount visible updated one cycle after the retiring state.

## Structure
- Package riscv_ctrl_pkg: opcode constants (OP_R, OP_LOAD, OP_STORE, OP_BRANCH), state enum, ImmSel and ALUOp encodings, branch Funct3 constants; shared with Immediate_generation consumers.
- Sub-module ctrl_out_decode: combinational state/Opcode -> control-vector map; FSM register, next-state logic and counter stay in top.

## Test plan
- Reset, zero-wait, Opcode=0110011: states FETCH,DECODE,EXEC_R,R_WB; RegWrite=1 only in cycle 4; InstrCount 0->1.
- Load, MemReady low 2 cycles in MEM_RD: MemReq held, total 7 cycles, MemToReg=1 with RegWrite in LOAD_WB, ImmSel=00.
- Branch Funct3=000: Zero=1 -> PCWrite=1, PCSrc=1; Zero=0 -> PCWrite=0; Funct3=001 inverted; ImmSel=10.
- Opcode=1101111: DECODE -> TRAP, Illegal=1, MemReq=0 indefinitely, InstrCount unchanged; rst clears.
- rst asserted during MEM_WR wait: MemReq/MemWrite drop same cycle, state FETCH after release, InstrCount=0.
- CNT_W=4, 16 stores retired: InstrCount wraps 15->0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// ALU and immediate selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_Z = 2'b11;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        LOAD_WB,
        MEM_WR,
        EXEC_R,
        R_WB,
        BRANCH,
        TRAP
    } state_t;

    // Immediate format depends only on the opcode, independent of FSM state.
    function automatic logic [1:0] imm_sel_of(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD:   imm_sel_of = IMM_I;
            OP_STORE:  imm_sel_of = IMM_S;
            OP_BRANCH: imm_sel_of = IMM_B;
            default:   imm_sel_of = IMM_Z;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational map from FSM state (plus Opcode/Funct3/Zero/MemReady) to the
// datapath control vector.
module ctrl_out_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_sel,
    output logic       illegal
);

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        imm_sel    = imm_sel_of(opcode);
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            EXEC_R: begin
                alu_op = ALU_FUNCT;
            end
            R_WB: begin
                reg_write = 1'b1;
            end
            MEM_ADDR: begin
                alu_src_b = 1'b1;
                alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                mem_req = 1'b1;
            end
            LOAD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
            end
            BRANCH: begin
                alu_op   = ALU_SUB;
                pc_src   = 1'b1;
                // Unsupported branch conditions simply fall through without a PC update.
                pc_write = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM (R-type, load, store, branch) with a
// retired-instruction counter.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Opcode,
    input  logic [2:0]       Funct3,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSel,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount
);

    state_t state;
    state_t next_state;
    logic   retire;

    logic       d_mem_req, d_mem_write, d_ir_write, d_pc_write, d_pc_src;
    logic       d_reg_write, d_mem_to_reg, d_alu_src_b, d_illegal;
    logic [1:0] d_alu_op, d_imm_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:    if (MemReady) next_state = DECODE;
            DECODE: begin
                case (Opcode)
                    OP_R:               next_state = EXEC_R;
                    OP_LOAD, OP_STORE:  next_state = MEM_ADDR;
                    OP_BRANCH:          next_state = BRANCH;
                    default:            next_state = TRAP;
                endcase
            end
            EXEC_R:   next_state = R_WB;
            R_WB:     next_state = FETCH;
            MEM_ADDR: next_state = (Opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:   if (MemReady) next_state = LOAD_WB;
            LOAD_WB:  next_state = FETCH;
            MEM_WR:   if (MemReady) next_state = FETCH;
            BRANCH:   next_state = FETCH;
            TRAP:     next_state = TRAP;
            default:  next_state = FETCH;
        endcase
    end

    assign retire = (state == R_WB) || (state == LOAD_WB) || (state == BRANCH)
                 || ((state == MEM_WR) && MemReady);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrCount <= '0;
        end else if (retire) begin
            InstrCount <= InstrCount + 1'b1;
        end
    end

    ctrl_out_decode u_decode (
        .state      (state),
        .opcode     (Opcode),
        .funct3     (Funct3),
        .zero       (Zero),
        .mem_ready  (MemReady),
        .mem_req    (d_mem_req),
        .mem_write  (d_mem_write),
        .ir_write   (d_ir_write),
        .pc_write   (d_pc_write),
        .pc_src     (d_pc_src),
        .reg_write  (d_reg_write),
        .mem_to_reg (d_mem_to_reg),
        .alu_src_b  (d_alu_src_b),
        .alu_op     (d_alu_op),
        .imm_sel    (d_imm_sel),
        .illegal    (d_illegal)
    );

    // Reset silences every output at once, even a request already in flight.
    assign MemReq   = d_mem_req    & ~rst;
    assign MemWrite = d_mem_write  & ~rst;
    assign IRWrite  = d_ir_write   & ~rst;
    assign PCWrite  = d_pc_write   & ~rst;
    assign PCSrc    = d_pc_src     & ~rst;
    assign RegWrite = d_reg_write  & ~rst;
    assign MemToReg = d_mem_to_reg & ~rst;
    assign ALUSrcB  = d_alu_src_b  & ~rst;
    assign ALUOp    = d_alu_op     & {2{~rst}};
    assign ImmSel   = d_imm_sel    & {2{~rst}};
    assign Illegal  = d_illegal    & ~rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control vectors and
// retired-instruction count, with a 4-bit counter to exercise wraparound.
module tb_multicycle_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       Opcode = 7'b0110011;
    logic [2:0]       Funct3 = 3'b000;
    logic             Zero = 1'b0;
    logic             MemReady = 1'b0;
    logic             MemReq, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite;
    logic             MemToReg, ALUSrcB, Illegal;
    logic [1:0]       ALUOp, ImmSel;
    logic [CNT_W-1:0] InstrCount;
    logic [12:0]      ctlv;

    int checks = 0;
    int errors = 0;

    // {MemReq,MemWrite,IRWrite,PCWrite,PCSrc,RegWrite,MemToReg,ALUSrcB,ALUOp,ImmSel,Illegal}
    localparam logic [12:0] V_ZERO       = 13'b0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [12:0] V_FETCH_WAIT = 13'b1_0_0_0_0_0_0_0_00_00_0;
    localparam logic [12:0] V_FETCH_GO   = 13'b1_0_1_1_0_0_0_0_00_00_0;
    localparam logic [12:0] V_DECODE     = 13'b0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [12:0] V_EXEC_R     = 13'b0_0_0_0_0_0_0_0_10_00_0;
    localparam logic [12:0] V_R_WB       = 13'b0_0_0_0_0_1_0_0_00_00_0;
    localparam logic [12:0] V_MEM_ADDR   = 13'b0_0_0_0_0_0_0_1_00_00_0;
    localparam logic [12:0] V_MEM_RD     = 13'b1_0_0_0_0_0_0_0_00_00_0;
    localparam logic [12:0] V_LOAD_WB    = 13'b0_0_0_0_0_1_1_0_00_00_0;
    localparam logic [12:0] V_MEM_WR     = 13'b1_1_0_0_0_0_0_0_00_00_0;
    localparam logic [12:0] V_BR_NT      = 13'b0_0_0_0_1_0_0_0_01_00_0;
    localparam logic [12:0] V_BR_T       = 13'b0_0_0_1_1_0_0_0_01_00_0;
    localparam logic [12:0] V_TRAP       = 13'b0_0_0_0_0_0_0_0_00_00_1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    assign ctlv = {MemReq, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite,
                   MemToReg, ALUSrcB, ALUOp, ImmSel, Illegal};

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .Opcode     (Opcode),
        .Funct3     (Funct3),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .MemReq     (MemReq),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemToReg   (MemToReg),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ImmSel     (ImmSel),
        .Illegal    (Illegal),
        .InstrCount (InstrCount)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] withImm(input logic [12:0] v, input logic [1:0] imm);
        withImm = v | {10'b0, imm, 1'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then check the control vector.
    task automatic applyStimulus(input string tag, input logic [12:0] expv,
                                 input logic ready, input logic zero);
        @(negedge clk);
        MemReady = ready;
        Zero     = zero;
        #1;
        checkOutput(tag, {19'b0, ctlv}, {19'b0, expv});
    endtask

    task automatic checkCount(input string tag, input int expected);
        @(posedge clk);
        #2;
        checkOutput(tag, {{(32-CNT_W){1'b0}}, InstrCount}, expected);
    endtask

    // Assert reset in the current cycle, hold it across two edges with MemReady high, then release.
    task automatic applyReset(input string tag, input logic [1:0] imm);
        rst      = 1'b1;
        MemReady = 1'b1;
        #1;
        checkOutput({tag, "_ctl_in_rst"}, {19'b0, ctlv}, {19'b0, V_ZERO});
        checkOutput({tag, "_cnt_in_rst"}, {{(32-CNT_W){1'b0}}, InstrCount}, 0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput({tag, "_ctl_held"}, {19'b0, ctlv}, {19'b0, V_ZERO});
        checkOutput({tag, "_cnt_held"}, {{(32-CNT_W){1'b0}}, InstrCount}, 0);
        @(negedge clk);
        rst      = 1'b0;
        MemReady = 1'b0;
        #1;
        checkOutput({tag, "_first_fetch"}, {19'b0, ctlv}, {19'b0, withImm(V_FETCH_WAIT, imm)});
    endtask

    task automatic runBranch(input string tag, input logic [2:0] f3, input logic zero,
                             input logic taken, input int countAfter);
        Funct3 = f3;
        applyStimulus({tag, "_fetch"}, withImm(V_FETCH_GO, 2'b10), 1'b1, zero);
        applyStimulus({tag, "_decode"}, withImm(V_DECODE, 2'b10), 1'b0, zero);
        applyStimulus({tag, "_branch"}, withImm(taken ? V_BR_T : V_BR_NT, 2'b10), 1'b0, zero);
        checkCount({tag, "_count"}, countAfter);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Power-on reset with an R-type opcode waiting in the IR.
        Opcode = OP_R;
        applyReset("por", 2'b11);

        // R-type, zero-wait: 4 cycles, RegWrite only in the last.
        applyStimulus("r_fetch", withImm(V_FETCH_GO, 2'b11), 1'b1, 1'b0);
        applyStimulus("r_decode", withImm(V_DECODE, 2'b11), 1'b0, 1'b0);
        applyStimulus("r_exec", withImm(V_EXEC_R, 2'b11), 1'b0, 1'b0);
        applyStimulus("r_wb", withImm(V_R_WB, 2'b11), 1'b0, 1'b0);
        checkCount("r_count", 1);

        // Load with two wait states in MEM_RD.
        Opcode = OP_LOAD;
        applyStimulus("ld_fetch", withImm(V_FETCH_GO, 2'b00), 1'b1, 1'b0);
        applyStimulus("ld_decode", withImm(V_DECODE, 2'b00), 1'b0, 1'b0);
        applyStimulus("ld_addr", withImm(V_MEM_ADDR, 2'b00), 1'b0, 1'b0);
        applyStimulus("ld_rd_wait1", withImm(V_MEM_RD, 2'b00), 1'b0, 1'b0);
        applyStimulus("ld_rd_wait2", withImm(V_MEM_RD, 2'b00), 1'b0, 1'b0);
        applyStimulus("ld_rd_done", withImm(V_MEM_RD, 2'b00), 1'b1, 1'b0);
        applyStimulus("ld_wb", withImm(V_LOAD_WB, 2'b00), 1'b1, 1'b0);
        checkCount("ld_count", 2);

        // Store with one fetch wait state.
        Opcode = OP_STORE;
        applyStimulus("st_fetch_wait", withImm(V_FETCH_WAIT, 2'b01), 1'b0, 1'b0);
        applyStimulus("st_fetch", withImm(V_FETCH_GO, 2'b01), 1'b1, 1'b0);
        applyStimulus("st_decode", withImm(V_DECODE, 2'b01), 1'b1, 1'b0);
        applyStimulus("st_addr", withImm(V_MEM_ADDR, 2'b01), 1'b1, 1'b0);
        applyStimulus("st_wr", withImm(V_MEM_WR, 2'b01), 1'b1, 1'b0);
        checkCount("st_count", 3);

        // Branch conditions, including an unsupported Funct3 that must not trap.
        Opcode = OP_BRANCH;
        runBranch("beq_z1", 3'b000, 1'b1, 1'b1, 4);
        runBranch("beq_z0", 3'b000, 1'b0, 1'b0, 5);
        runBranch("bne_z0", 3'b001, 1'b0, 1'b1, 6);
        runBranch("bne_z1", 3'b001, 1'b1, 1'b0, 7);
        runBranch("blt_z1", 3'b100, 1'b1, 1'b0, 8);

        // Unsupported opcode: parks in TRAP, ignores MemReady, does not count.
        Opcode = OP_JAL;
        applyStimulus("trap_fetch", withImm(V_FETCH_GO, 2'b11), 1'b1, 1'b0);
        applyStimulus("trap_decode", withImm(V_DECODE, 2'b11), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("trap_hold", withImm(V_TRAP, 2'b11), i[0], 1'b0);
        end
        checkCount("trap_count", 8);
        Opcode = OP_STORE;
        applyReset("trap_rst", 2'b01);

        // One clean store, then a store aborted by reset mid memory wait.
        applyStimulus("st2_fetch", withImm(V_FETCH_GO, 2'b01), 1'b1, 1'b0);
        applyStimulus("st2_decode", withImm(V_DECODE, 2'b01), 1'b0, 1'b0);
        applyStimulus("st2_addr", withImm(V_MEM_ADDR, 2'b01), 1'b0, 1'b0);
        applyStimulus("st2_wr", withImm(V_MEM_WR, 2'b01), 1'b1, 1'b0);
        checkCount("st2_count", 1);
        applyStimulus("ab_fetch", withImm(V_FETCH_GO, 2'b01), 1'b1, 1'b0);
        applyStimulus("ab_decode", withImm(V_DECODE, 2'b01), 1'b0, 1'b0);
        applyStimulus("ab_addr", withImm(V_MEM_ADDR, 2'b01), 1'b0, 1'b0);
        applyStimulus("ab_wr_wait", withImm(V_MEM_WR, 2'b01), 1'b0, 1'b0);
        applyReset("abort_rst", 2'b01);

        // Sixteen zero-wait stores wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) begin
            applyStimulus("wrap_fetch", withImm(V_FETCH_GO, 2'b01), 1'b1, 1'b0);
            applyStimulus("wrap_decode", withImm(V_DECODE, 2'b01), 1'b0, 1'b0);
            applyStimulus("wrap_addr", withImm(V_MEM_ADDR, 2'b01), 1'b0, 1'b0);
            applyStimulus("wrap_wr", withImm(V_MEM_WR, 2'b01), 1'b1, 1'b0);
            checkCount("wrap_count", (i + 1) % 16);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
